// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the CPU/DMA system RAM port arbiter.
package ram_arb_pkg;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;
endpackage

// File: rtl/arb_starve_counter.sv
// Counts CPU grants taken while DMA waits; forces a DMA grant at LIMIT.
module arb_starve_counter
  import ram_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       idle,
  input  logic       cpu_grant,
  input  logic       dma_grant,
  input  logic       dma_req,
  output logic       force_dma,
  output logic [3:0] cnt
);
  localparam logic [3:0] LIM = 4'(LIMIT);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)                               cnt <= '0;
    else if (dma_grant || (idle && !dma_req)) cnt <= '0;
    else if (cpu_grant && dma_req && cnt != LIM) cnt <= cnt + 4'd1;
  end

  assign force_dma = dma_req && (cnt == LIM);
endmodule

// File: rtl/ram_port_arbiter.sv
// CPU/DMA arbiter for the single-port system RAM; fixed CPU priority with a
// DMA starvation guard. Define RAM_WP_EN to block DMA writes below WP_LIMIT.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int              ADDR_W       = DEF_ADDR_W,
  parameter int              DATA_W       = DEF_DATA_W,
  parameter int              STARVE_LIMIT = 4,
  parameter logic [ADDR_W-1:0] WP_LIMIT   = ADDR_W'(9'h100)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner
);
`ifdef RAM_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  arb_state_t        state;
  logic              we_q, err_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
  logic              force_dma, dma_win, grant, blocked;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [3:0]        starve_cnt;

  assign grant     = (state == IDLE) && (cpu_req || dma_req);
  assign dma_win   = force_dma || !cpu_req;
  assign win_we    = dma_win ? dma_we    : cpu_we;
  assign win_addr  = dma_win ? dma_addr  : cpu_addr;
  assign win_wdata = dma_win ? dma_wdata : cpu_wdata;
  // A blocked DMA write still runs the full sequence, just without the strobe.
  assign blocked   = WP_EN && dma_win && dma_we && (dma_addr < WP_LIMIT);

  arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .Clock     (Clock),
    .Reset     (Reset),
    .idle      (state == IDLE),
    .cpu_grant (grant && !dma_win),
    .dma_grant (grant && dma_win),
    .dma_req   (dma_req),
    .force_dma (force_dma),
    .cnt       (starve_cnt)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_we      <= 1'b0;
      owner       <= OWN_CPU;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          state     <= ACCESS;
          ram_addr  <= win_addr;
          ram_wdata <= win_wdata;
          ram_we    <= win_we && !blocked;
          owner     <= dma_win;
          we_q      <= win_we;
          err_q     <= blocked;
        end
        ACCESS: begin
          ram_we <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          state <= IDLE;
          if (!we_q) begin
            if (owner == OWN_DMA) dma_rdata_q <= ram_rdata;
            else                  cpu_rdata_q <= ram_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign cpu_ack   = (state == RESP) && (owner == OWN_CPU);
  assign dma_ack   = (state == RESP) && (owner == OWN_DMA);
  // Read data flows straight through during the ack cycle, then holds.
  assign cpu_rdata = (cpu_ack && !we_q) ? ram_rdata : cpu_rdata_q;
  assign dma_rdata = (dma_ack && !we_q) ? ram_rdata : dma_rdata_q;
  assign dma_err   = dma_ack && err_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed, table-driven bench for ram_port_arbiter with a behavioural RAM.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [8:0]  cpu_addr = '0, dma_addr = '0;
  logic [31:0] cpu_wdata = '0, dma_wdata = '0;
  logic        cpu_ack, dma_ack, dma_err, ram_we, busy, owner;
  logic [31:0] cpu_rdata, dma_rdata, ram_wdata, ram_rdata;
  logic [8:0]  ram_addr;
  logic        preload = 1'b1;
  logic [31:0] mem [512];

  always #5 Clock = ~Clock;

  ram_port_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .busy(busy), .owner(owner)
  );

  function automatic logic [31:0] pre(logic [8:0] a);
    return 32'h5A00_0000 | {23'd0, a};
  endfunction

  // Synchronous-read RAM model
  always @(posedge Clock) begin
    if (preload) for (int i = 0; i < 512; i++) mem[i] <= pre(9'(i));
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

`ifdef RAM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  int n_cmp = 0, n_bad = 0;
  logic [31:0] last_cpu = '0, last_dma = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        dma;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int idx);
    logic got, ack, oth;
    logic [31:0] rd, exp_rd;
    got = 1'b0;
    exp_rd = v.we ? (v.dma ? last_dma : last_cpu) : v.exp_rd;
    if (v.dma) begin
      dma_req = 1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
    end else begin
      cpu_req = 1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge Clock);
      ack = v.dma ? dma_ack : cpu_ack;
      oth = v.dma ? cpu_ack : dma_ack;
      rd  = v.dma ? dma_rdata : cpu_rdata;
      if (c == 1) begin
        chk($sformatf("v%0d_we_c1", idx), 32'(ram_we), 32'(v.we && !v.exp_err));
        chk($sformatf("v%0d_owner", idx), 32'(owner), 32'(v.dma));
        chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
      end
      if (ack) begin
        got = 1'b1;
        chk($sformatf("v%0d_ack_cycle", idx), 32'(c), 32'd2);
        chk($sformatf("v%0d_we_c2", idx), 32'(ram_we), 32'd0);
        chk($sformatf("v%0d_rdata", idx), rd, exp_rd);
        chk($sformatf("v%0d_err", idx), 32'(dma_err), 32'(v.exp_err));
        chk($sformatf("v%0d_other_ack", idx), 32'(oth), 32'd0);
        cpu_req = 0; dma_req = 0;
      end
    end
    if (!got) begin
      chk($sformatf("v%0d_ack_timeout", idx), 32'd0, 32'd1);
      cpu_req = 0; dma_req = 0;
    end
    if (v.dma) last_dma = exp_rd; else last_cpu = exp_rd;
    @(negedge Clock);
    rd = v.dma ? dma_rdata : cpu_rdata;
    chk($sformatf("v%0d_held", idx), rd, exp_rd);
    chk($sformatf("v%0d_idle", idx), {29'd0, busy, cpu_ack, dma_ack}, 32'd0);
  endtask

  initial begin
    int n, k, last;
    vecs[0] = '{1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 9'h100, 32'hCAFEF00D, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 9'h100, 32'h0, 32'hCAFEF00D, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 9'h1F0, 32'h0, pre(9'h1F0), 1'b0};
    vecs[5] = '{1'b1, 1'b1, 9'h0FF, 32'h12345678, 32'h0, WP};
    vecs[6] = '{1'b0, 1'b0, 9'h0FF, 32'h0, WP ? pre(9'h0FF) : 32'h12345678, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0};

    repeat (2) @(negedge Clock);
    preload = 1'b0;
    chk("reset_ctrl", {26'd0, busy, ram_we, cpu_ack, dma_ack, dma_err, owner}, 32'd0);
    chk("reset_addr", {23'd0, ram_addr}, 32'd0);
    chk("reset_wdata", ram_wdata, 32'd0);
    chk("reset_rdata", cpu_rdata | dma_rdata, 32'd0);
    Reset = 1'b1;

    // Idle: no requests, nothing happens
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      chk($sformatf("idle_c%0d", c), {27'd0, busy, ram_we, cpu_ack, dma_ack, dma_err}, 32'd0);
    end
    chk("idle_starve_cnt", 32'(dut.u_starve.cnt), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Simultaneous requests with CPU held high: C C C C D C
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
    dma_req = 1; dma_we = 0; dma_addr = 9'h1F1;
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge Clock);
      if (cpu_ack || dma_ack) begin
        chk($sformatf("starve_g%0d_dma", n), 32'(dma_ack), 32'(n == 4));
        chk($sformatf("starve_g%0d_cpu", n), 32'(cpu_ack), 32'(n != 4));
        if (n == 3) chk("starve_cnt_sat", 32'(dut.u_starve.cnt), 32'd4);
        if (dma_ack) begin
          chk("starve_dma_rdata", dma_rdata, pre(9'h1F1));
          dma_req = 0;
        end
        n++;
        if (n == 6) cpu_req = 0;
      end
    end
    if (n < 6) chk("starve_timeout", 32'(n), 32'd6);
    cpu_req = 0; dma_req = 0;
    @(negedge Clock);
    chk("starve_cleared", 32'(dut.u_starve.cnt), 32'd0);

    // DMA-only back-to-back read stream
    dma_req = 1; dma_we = 0; dma_addr = 9'h1F0;
    k = 0; last = 0;
    for (int c = 1; c <= 40 && k < 3; c++) begin
      @(negedge Clock);
      chk($sformatf("stream_c%0d_cpu_ack", c), 32'(cpu_ack), 32'd0);
      if (dma_ack) begin
        chk($sformatf("stream_r%0d_gap", k), 32'(c - last), (k == 0) ? 32'd2 : 32'd3);
        chk($sformatf("stream_r%0d_owner", k), 32'(owner), 32'(OWN_DMA));
        chk($sformatf("stream_r%0d_data", k), dma_rdata, pre(9'h1F0 + 9'(k)));
        last = c;
        k++;
        if (k == 3) dma_req = 0; else dma_addr = 9'h1F0 + 9'(k);
      end
    end
    if (k < 3) chk("stream_timeout", 32'(k), 32'd3);
    dma_req = 0;
    @(negedge Clock);

    // Reset during ACCESS of a CPU write aborts it
    cpu_req = 1; cpu_we = 1; cpu_addr = 9'h020; cpu_wdata = 32'h1111_2222;
    @(negedge Clock);
    chk("rst_we_before", 32'(ram_we), 32'd1);
    Reset = 1'b0;
    #1;
    chk("rst_we_dropped", {30'd0, ram_we, busy}, 32'd0);
    cpu_req = 0; cpu_we = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      chk($sformatf("rst_no_ack_c%0d", c), 32'(cpu_ack), 32'd0);
    end
    Reset = 1'b1;
    @(negedge Clock);
    chk("rst_released_idle", {30'd0, busy, cpu_ack}, 32'd0);
    last_cpu = '0; last_dma = '0;
    run_vec('{1'b0, 1'b0, 9'h020, 32'h0, pre(9'h020), 1'b0}, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
